// File: rtl/spio_uart_pkt_framer.sv
// Frames one SpiNNaker packet (40/72-bit) into a SYNC-delimited, byte-stuffed,
// XOR-checksummed byte stream feeding spio_uart_tx.
module spio_uart_pkt_framer #(
  parameter logic [7:0] SYNC_BYTE = 8'h7E,
  parameter logic [7:0] ESC_BYTE  = 8'h7D,
  parameter logic [7:0] ESC_XOR   = 8'h20
) (
  input  logic        tx_clk_i,
  input  logic        rx_reset_i,
  input  logic [71:0] PKT_DATA_IN,
  input  logic        PKT_VLD_IN,
  output logic        PKT_RDY_OUT,
  output logic [7:0]  DATA_OUT,
  output logic        VLD_OUT,
  input  logic        RDY_IN,
  output logic [15:0] FRAME_CNT_OUT
);

  // state    | meaning
  // IDLE     | waiting for a packet, PKT_RDY_OUT high
  // SYNC     | presenting the frame delimiter
  // DATA     | presenting payload byte idx (or ESC_BYTE when it needs stuffing)
  // DATA_ESC | presenting the escaped form of payload byte idx
  // CSUM     | presenting the checksum (or ESC_BYTE when it needs stuffing)
  // CSUM_ESC | presenting the escaped checksum
  typedef enum logic [2:0] {IDLE, SYNC, DATA, DATA_ESC, CSUM, CSUM_ESC} state_t;

  state_t      state_q, state_d;
  logic [71:0] pkt_q, pkt_d;
  logic        long_q, long_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  data_q, data_d;
  logic        vld_q, vld_d;
  logic        rdy_q, rdy_d;
  logic [15:0] cnt_q, cnt_d;

  logic [7:0]  pay [0:8];
  logic [7:0]  cur_byte, nxt_byte, csum_in;
  logic [3:0]  idx_inc;
  logic        hs, capture, last;

  function automatic logic needs_esc(input logic [7:0] b);
    return (b == SYNC_BYTE) || (b == ESC_BYTE);
  endfunction

  // First byte put on the wire for payload/checksum value b.
  function automatic logic [7:0] lead(input logic [7:0] b);
    return needs_esc(b) ? ESC_BYTE : b;
  endfunction

  always_comb begin
    for (int i = 0; i < 9; i++) pay[i] = pkt_q[8*i +: 8];
  end

  always_comb begin
    csum_in = PKT_DATA_IN[7:0] ^ PKT_DATA_IN[15:8] ^ PKT_DATA_IN[23:16]
            ^ PKT_DATA_IN[31:24] ^ PKT_DATA_IN[39:32];
    if (PKT_DATA_IN[1])
      csum_in = csum_in ^ PKT_DATA_IN[47:40] ^ PKT_DATA_IN[55:48]
              ^ PKT_DATA_IN[63:56] ^ PKT_DATA_IN[71:64];
  end

  assign idx_inc  = idx_q + 4'd1;
  assign cur_byte = pay[idx_q];
  assign nxt_byte = pay[idx_inc];
  assign last     = (idx_q == (long_q ? 4'd8 : 4'd4));
  assign hs       = vld_q && RDY_IN;
  assign capture  = PKT_VLD_IN && rdy_q;

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    long_d  = long_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    data_d  = data_q;
    vld_d   = vld_q;
    rdy_d   = rdy_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (capture) begin
          pkt_d   = PKT_DATA_IN;
          long_d  = PKT_DATA_IN[1];
          csum_d  = csum_in;
          idx_d   = 4'd0;
          rdy_d   = 1'b0;
          data_d  = SYNC_BYTE;
          vld_d   = 1'b1;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (hs) begin
          data_d  = lead(pay[0]);
          state_d = DATA;
        end
      end
      DATA, DATA_ESC: begin
        if (hs) begin
          if (state_q == DATA && needs_esc(cur_byte)) begin
            data_d  = cur_byte ^ ESC_XOR;
            state_d = DATA_ESC;
          end else if (last) begin
            data_d  = lead(csum_q);
            state_d = CSUM;
          end else begin
            idx_d   = idx_inc;
            data_d  = lead(nxt_byte);
            state_d = DATA;
          end
        end
      end
      CSUM: begin
        if (hs) begin
          if (needs_esc(csum_q)) begin
            data_d  = csum_q ^ ESC_XOR;
            state_d = CSUM_ESC;
          end else begin
            vld_d   = 1'b0;
            rdy_d   = 1'b1;
            cnt_d   = cnt_q + 16'd1;
            state_d = IDLE;
          end
        end
      end
      CSUM_ESC: begin
        if (hs) begin
          vld_d   = 1'b0;
          rdy_d   = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk_i or negedge rx_reset_i) begin
    if (!rx_reset_i) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      long_q  <= 1'b0;
      idx_q   <= '0;
      csum_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      long_q  <= long_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PKT_RDY_OUT   = rdy_q;
  assign DATA_OUT      = data_q;
  assign VLD_OUT       = vld_q;
  assign FRAME_CNT_OUT = cnt_q;

endmodule
